// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the parameterised register file.
// Holds default widths plus data/address types sized to those defaults.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address compare, bypass mux, data and valid regs.
// Ports: clk, rst, i_rd/i_addr request, i_wr/i_waddr/i_wdata write snoop,
//        i_rdata array word at i_addr, o_data/o_valid registered result.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rd,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid
);

   logic              w_zero;
   logic              w_fwd;
   logic [DATA_W-1:0] w_next;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;

   // Register 0 reads as zero and is never forwarded when hard-wired.
   assign w_zero = (ZERO_REG != 0) && (i_addr == '0);
   assign w_fwd  = (BYPASS != 0) && i_wr
                && (i_waddr == i_addr) && !w_zero;

   always_comb begin
      w_next = i_rdata;
      if (w_zero)
         w_next = '0;
      else if (w_fwd)
         w_next = i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_rd;
         if (i_rd)
            r_data <= w_next;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/param_register_file.sv
// Parameterised register file, one write port and two registered read ports.
// Ports: clk, rst, W_wr/W_addr/W_data write, Rp_*/Rq_* read request,
//        Rp_data1/Rq_data2 read data, Rp_valid/Rq_valid one-cycle strobes.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              W_wr,
   input  logic [ADDR_W-1:0] W_addr,
   input  logic [DATA_W-1:0] W_data,
   input  logic              Rp_rd,
   input  logic              Rq_rd,
   input  logic [ADDR_W-1:0] Rp_addr1,
   input  logic [ADDR_W-1:0] Rq_addr2,
   output logic [DATA_W-1:0] Rp_data1,
   output logic [DATA_W-1:0] Rq_data2,
   output logic              Rp_valid,
   output logic              Rq_valid
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_we;

   // Writes to a hard-wired register 0 are dropped.
   assign w_we = W_wr && !((ZERO_REG != 0) && (W_addr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_we) begin
         r_mem[W_addr] <= W_data;
      end
   end

   rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port_p (
      .clk     (clk),
      .rst     (rst),
      .i_rd    (Rp_rd),
      .i_addr  (Rp_addr1),
      .i_wr    (W_wr),
      .i_waddr (W_addr),
      .i_wdata (W_data),
      .i_rdata (r_mem[Rp_addr1]),
      .o_data  (Rp_data1),
      .o_valid (Rp_valid)
   );

   rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_port_q (
      .clk     (clk),
      .rst     (rst),
      .i_rd    (Rq_rd),
      .i_addr  (Rq_addr2),
      .i_wr    (W_wr),
      .i_waddr (W_addr),
      .i_wdata (W_data),
      .i_rdata (r_mem[Rq_addr2]),
      .o_data  (Rq_data2),
      .o_valid (Rq_valid)
   );

endmodule
